// File: rtl/alu_mul_seq.sv
// alu_mul_seq
// ----------------------------------------------------------------------------
// Sequences the shared datapath ALU to run an unsigned WIDTH x WIDTH
// shift-and-add multiply. The product is reported modulo 2^WIDTH, with a
// sticky overflow flag that is set when the true product needs more than
// WIDTH bits. Latency is fixed, so microcode can count cycles.
//
// Each multiplier bit takes two ALU operations:
//   ADD : prod <= prod + mcand when the multiplier LSB is 1. Otherwise the
//         ALU passes prod through unchanged.
//   DBL : mcand <= mcand + mcand, and the multiplier shifts right by one.
// All WIDTH iterations always run, even when mcand has shifted out to zero.
//
// Ports
//   clk        : system clock, rising edge
//   reset_bar  : asynchronous active-low reset
//   start      : request a multiply; only sampled in IDLE
//   abort      : synchronous cancel while busy (ADD/DBL)
//   a, b       : multiplicand and multiplier, captured on an accepted start
//   busy       : high in ADD/DBL
//   done       : one-cycle pulse; result/ovf are valid from this cycle on
//   result     : product mod 2^WIDTH; held until the next completed multiply
//   ovf        : sticky overflow for the held result
//   alu_x/y/c  : ALU operands and control word {ex,nx,ey,ny,f,no}
//   alu_cin    : ALU carry-in, tied to 0
//   alu_out    : ALU result, combinational from alu_x/alu_y/alu_c
//   alu_cflag  : ALU carry-out
//   dbg_state  : current FSM state (0 IDLE, 1 ADD, 2 DBL, 3 DONE)
//
// Handshake: start has no ready signal. It is accepted on any rising edge
// where the FSM is in IDLE and start=1, even if abort is also high. A start
// seen in any other state is dropped, not queued. Completion is signalled by
// a single done pulse in the cycle after the last DBL edge. There is no
// back-pressure on done. An abort gives no done pulse and leaves result/ovf
// unchanged.
// ----------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int          WIDTH    = 16,
    parameter logic [5:0]  CW_ADD   = 6'b101010,
    parameter logic [5:0]  CW_PASSX = 6'b100010
) (
    input  logic             clk,
    input  logic             reset_bar,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [5:0]       alu_c,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cflag,
    output logic [1:0]       dbg_state
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DBL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  prod;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mplier;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_acc;     // overflow for the multiply in progress
    logic [WIDTH-1:0]  result_q;    // last completed product
    logic              ovf_q;       // overflow of last completed product

    logic [WIDTH-1:0]  mplier_shr;
    logic              add_ovf;
    logic              dbl_ovf;
    logic              last_iter;

    assign mplier_shr = mplier >> 1;
    // A carry out of the ADD step always loses product bits.
    assign add_ovf    = mplier[0] & alu_cflag;
    // A doubling carry only matters if a later multiplier bit would add the
    // lost mcand bit back into the product.
    assign dbl_ovf    = alu_cflag & (|mplier_shr);
    assign last_iter  = (cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and ALU drive
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        alu_x      = '0;
        alu_y      = '0;
        alu_c      = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ADD;
                end
            end
            S_ADD: begin
                busy  = 1'b1;
                alu_x = prod;
                alu_y = mcand;
                alu_c = mplier[0] ? CW_ADD : CW_PASSX;
                state_next = abort ? S_IDLE : S_DBL;
            end
            S_DBL: begin
                busy  = 1'b1;
                alu_x = mcand;
                alu_y = mcand;
                alu_c = CW_ADD;
                if (abort) begin
                    state_next = S_IDLE;
                end else if (last_iter) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_ADD;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand   <= a;
                        mplier  <= b;
                        prod    <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= '0;
                    end
                end
                S_ADD: begin
                    if (!abort) begin
                        prod <= alu_out;
                        if (add_ovf) begin
                            ovf_acc <= 1'b1;
                        end
                    end
                end
                S_DBL: begin
                    if (!abort) begin
                        mcand  <= alu_out;
                        mplier <= mplier_shr;
                        if (dbl_ovf) begin
                            ovf_acc <= 1'b1;
                        end
                        if (last_iter) begin
                            // prod is final after the last ADD. Publish it
                            // together with this edge's overflow contribution.
                            result_q <= prod;
                            ovf_q    <= ovf_acc | dbl_ovf;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result    = result_q;
    assign ovf       = ovf_q;
    assign alu_cin   = 1'b0;
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    localparam logic [5:0] CW_ADD   = 6'b101010;
    localparam logic [5:0] CW_PASSX = 6'b100010;

    logic        clk;
    logic        reset_bar;
    logic        start;
    logic        abort;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_c;
    logic        alu_cin;
    logic [15:0] alu_out;
    logic        alu_cflag;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected held result/ovf, maintained from the bench's own expectations.
    logic [15:0] hold_r;
    logic        hold_o;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk       (clk),
        .reset_bar (reset_bar),
        .start     (start),
        .abort     (abort),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .ovf       (ovf),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_c     (alu_c),
        .alu_cin   (alu_cin),
        .alu_out   (alu_out),
        .alu_cflag (alu_cflag),
        .dbg_state (dbg_state)
    );

    // ---------------- ALU model ----------------
    // The control word is {ex,nx,ey,ny,f,no}. ex/ey gate an operand, nx/ny
    // invert it, f selects add or and, and no inverts the output.
    always_comb begin
        logic [15:0] xx;
        logic [15:0] yy;
        logic [16:0] s;
        logic [15:0] r;
        xx = alu_c[5] ? alu_x : 16'h0;
        if (alu_c[4]) xx = ~xx;
        yy = alu_c[3] ? alu_y : 16'h0;
        if (alu_c[2]) yy = ~yy;
        if (alu_c[1]) begin
            s = {1'b0, xx} + {1'b0, yy};
        end else begin
            s = {1'b0, xx & yy};
        end
        r = alu_c[0] ? ~s[15:0] : s[15:0];
        alu_out   = r;
        alu_cflag = s[16];
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_bar = 1'b0;
        start = 1'b0; abort = 1'b0; a = 16'h0; b = 16'h0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b state=%0d, expected 0/0/0", busy, done, dbg_state);
        end
        checks++;
        if (result !== 16'h0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: result=%h ovf=%b, expected 0000/0", result, ovf);
        end
        checks++;
        if (alu_x !== 16'h0 || alu_y !== 16'h0 || alu_c !== 6'h0 || alu_cin !== 1'b0) begin
            errors++;
            $display("FAIL reset_alu: x=%h y=%h c=%b cin=%b, expected all 0", alu_x, alu_y, alu_c, alu_cin);
        end
        repeat (2) @(negedge clk);
        reset_bar = 1'b1;
        @(negedge clk);
        hold_r = 16'h0;
        hold_o = 1'b0;
    endtask

    // Start one multiply and follow it to completion. If ign_at >= 0, a
    // second start with a=b=1 is presented for one cycle in busy cycle ign_at.
    task automatic run_mul(input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic [15:0] exp_r, input logic exp_o,
                           input int ign_at, input string name);
        int busy_cnt;
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == ign_at) begin
                a = 16'h1; b = 16'h1; start = 1'b1;
            end else if (i == ign_at + 1) begin
                start = 1'b0;
            end
            if (busy === 1'b1) busy_cnt++;
            checks++;
            if (done !== 1'b0 || result !== hold_r || ovf !== hold_o) begin
                errors++;
                $display("FAIL %s_hold c%0d: done=%b result=%h ovf=%b, expected 0/%h/%b",
                         name, i, done, result, ovf, hold_r, hold_o);
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (busy_cnt !== 32) begin
            errors++;
            $display("FAIL %s_latency: busy cycles=%0d, expected 32", name, busy_cnt);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd3) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b state=%0d, expected 1/0/3", name, done, busy, dbg_state);
        end
        checks++;
        if (result !== exp_r || ovf !== exp_o) begin
            errors++;
            $display("FAIL %s_result: result=%h ovf=%b, expected %h/%b", name, result, ovf, exp_r, exp_o);
        end
        checks++;
        if (alu_x !== 16'h0 || alu_y !== 16'h0 || alu_c !== 6'h0 || alu_cin !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_alu: x=%h y=%h c=%b cin=%b, expected all 0", name, alu_x, alu_y, alu_c, alu_cin);
        end
        hold_r = exp_r;
        hold_o = exp_o;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || dbg_state !== 2'd0 || result !== exp_r || ovf !== exp_o) begin
            errors++;
            $display("FAIL %s_idle: done=%b state=%0d result=%h ovf=%b, expected 0/0/%h/%b",
                     name, done, dbg_state, result, ovf, exp_r, exp_o);
        end
        checks++;
        if (alu_x !== 16'h0 || alu_y !== 16'h0 || alu_c !== 6'h0) begin
            errors++;
            $display("FAIL %s_idle_alu: x=%h y=%h c=%b, expected all 0", name, alu_x, alu_y, alu_c);
        end
    endtask

    // 3 x 5 with a per-cycle check of the ALU drive.
    task automatic test_alu_sequence();
        logic [15:0] mb;
        logic [15:0] e_prod;
        logic [15:0] e_mcand;
        logic [5:0]  e_c;
        mb = 16'd5;
        e_prod = 16'd0;
        e_mcand = 16'd3;
        a = 16'd3; b = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) begin
                e_c = mb[i/2] ? CW_ADD : CW_PASSX;
                checks++;
                if (alu_c !== e_c || alu_x !== e_prod || alu_y !== e_mcand || alu_cin !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_add c%0d: x=%h y=%h c=%b cin=%b, expected %h/%h/%b/0",
                             i, alu_x, alu_y, alu_c, alu_cin, e_prod, e_mcand, e_c);
                end
                if (mb[i/2]) e_prod = e_prod + e_mcand;
            end else begin
                checks++;
                if (alu_c !== CW_ADD || alu_x !== e_mcand || alu_y !== e_mcand || alu_cin !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_dbl c%0d: x=%h y=%h c=%b cin=%b, expected %h/%h/%b/0",
                             i, alu_x, alu_y, alu_c, alu_cin, e_mcand, e_mcand, CW_ADD);
                end
                e_mcand = e_mcand << 1;
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || result !== 16'd15 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL seq_result: done=%b result=%h ovf=%b, expected 1/000f/0", done, result, ovf);
        end
        hold_r = 16'd15;
        hold_o = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_mul(16'd3,    16'd5,    16'd15,   1'b0, -1, "mul_3x5");
        run_mul(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, -1, "mul_ffff");
        run_mul(16'h00FF, 16'h0101, 16'hFFFF, 1'b0, -1, "mul_ff_101");
        run_mul(16'h0100, 16'h0100, 16'h0000, 1'b1, -1, "mul_100");
        run_mul(16'h0000, 16'h1234, 16'h0000, 1'b0, -1, "mul_zero");
    endtask

    task automatic test_start_ignored();
        run_mul(16'd7, 16'd9, 16'd63, 1'b0, 5, "ignore_start");
    endtask

    task automatic test_abort();
        int done_cnt;
        a = 16'd2; b = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b state=%0d, expected 0/0", busy, dbg_state);
        end
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        checks++;
        if (done_cnt !== 0 || result !== 16'd63 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: done pulses=%0d result=%h ovf=%b, expected 0/003f/0", done_cnt, result, ovf);
        end
        // start and abort together in IDLE: start is accepted.
        a = 16'd4; b = 16'd5; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_over_abort: busy=%b, expected 1", busy);
        end
        done_cnt = 0;
        for (int i = 0; i < 40 && done_cnt == 0; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt = i + 1;
        end
        checks++;
        if (done_cnt !== 32 || result !== 16'd20 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL start_over_abort_result: done at=%0d result=%h ovf=%b, expected 32/0014/0",
                     done_cnt, result, ovf);
        end
        hold_r = 16'd20;
        hold_o = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        a = 16'd4; b = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (alu_x !== 16'd16 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: x=%h busy=%b, expected 0010/1", alu_x, busy);
        end
        #2 reset_bar = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0 || result !== 16'h0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b state=%0d result=%h ovf=%b, expected all 0",
                     busy, done, dbg_state, result, ovf);
        end
        checks++;
        if (alu_x !== 16'h0 || alu_y !== 16'h0 || alu_c !== 6'h0) begin
            errors++;
            $display("FAIL async_reset_alu: x=%h y=%h c=%b, expected all 0", alu_x, alu_y, alu_c);
        end
        hold_r = 16'h0;
        hold_o = 1'b0;
        @(negedge clk);
        reset_bar = 1'b1;
        @(negedge clk);
        run_mul(16'd2, 16'd3, 16'd6, 1'b0, -1, "after_reset");
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        test_reset();
        test_alu_sequence();
        test_basic();
        test_start_ignored();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
